spmv_val_rd_arbiter: RTL
========================

Name: spmv_val_rd_arbiter

Overview:
- Shares the single HBM Val AXI port among CONF_NUM_KERNEL spmv calc kernels. Each kernel owns one Val read master.
- Sits between the kernel Val masters and m_axi_hbm_Val_*, filling the Val crossbar slot in the spmv top level.
- Val traffic is read-only. The block does round-robin AR arbitration and returns R bursts in order via a grant-order FIFO.
- The write channels are tied off.

Parameters:
- CONF_NUM_KERNEL, 4, number of kernel Val masters (>=2).
- OUTSTANDING_DEPTH, 16, max in-flight read bursts (power of 2).
- ADDR_W, 48, AXI address width.
- DATA_W, 256, AXI data width.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- s_axi_Val_araddr/arlen/arsize/arburst  in  N*48/N*8/N*3/N*2  per-kernel AR fields, kernel i at slice i.
- s_axi_Val_arvalid  in  N  per-kernel AR valid.
- s_axi_Val_arready  out  N  per-kernel AR ready.
- s_axi_Val_rdata/rresp/rlast  out  N*256/N*2/N  per-kernel R data, response and last.
- s_axi_Val_rvalid  out  N  per-kernel R valid.
- s_axi_Val_rready  in  N  per-kernel R ready.
- s_axi_Val_awready/wready/bvalid  out  N each  tied 0.
- s_axi_Val_bresp  out  N*2  tied 0.
- m_axi_hbm_Val_araddr/arlen/arsize/arburst/arvalid  out  48/8/3/2/1  HBM AR channel.
- m_axi_hbm_Val_arready  in  1  HBM AR ready.
- m_axi_hbm_Val_rdata/rresp/rlast/rvalid  in  256/2/1/1  HBM R channel.
- m_axi_hbm_Val_rready  out  1  HBM R ready.
- m_axi_hbm_Val_aw*/w*  out  various  all 0; m_axi_hbm_Val_bready out 1.
- outstanding  out  $clog2(OUTSTANDING_DEPTH)+1  in-flight burst count.
- err_unexpected_r  out  1  sticky: R beat arrived with no owner.

Behaviour:
- Reset (rstn=0 at posedge clk):
  - m_arvalid=0, order FIFO empty, outstanding=0, rr_ptr=0, err_unexpected_r=0.
  - All s_arready=0 and all s_rvalid=0.
  - AR fields reset to 0.
  - Reset mid-burst discards all in-flight state; the HBM side must be reset with it.
- AR arbitration:
  - grant_en = (m_arvalid==0 || m_arready) && outstanding < OUTSTANDING_DEPTH.
  - Winner = first i with s_arvalid[i], searching from rr_ptr upward, wrapping modulo N.
  - s_arready = one-hot(winner) & grant_en, combinational; at most one bit is high.
  - On grant: latch AR fields into the output register, set m_arvalid=1 next cycle, push winner index into the order FIFO, set rr_ptr = (winner+1) mod N.
  - m_arvalid and its fields hold stable until m_arready.
  - Back-to-back grants are allowed, since grant_en includes m_arready in the same cycle.
  - Latency: kernel AR handshake at cycle t gives m_arvalid at t+1.
- Full condition: outstanding == DEPTH deasserts all s_arready. A pop in the same cycle does not enable a grant; the grant happens next cycle.
- R routing (combinational, zero latency):
  - owner = FIFO head.
  - While the FIFO is non-empty:
    - s_rvalid[owner] = m_rvalid; other rvalid bits are 0.
    - m_rready = s_rready[owner].
    - rdata, rresp and rlast are broadcast to all slices.
  - Pop on m_rvalid && m_rready && m_rlast.
- outstanding counter:
  - +1 on push, -1 on pop.
  - Simultaneous push and pop leaves it unchanged.
  - The FIFO count is the single source of truth.
- Empty FIFO with m_rvalid=1: m_rready=0, all s_rvalid=0, err_unexpected_r set sticky until reset.
- rresp is passed through unmodified; the arbiter does not act on errors.
- Write channels: s_awready, s_wready and s_bvalid are 0; all m_aw*/w* outputs are 0; m_bready=1.

Decomposition:
- Package spmv_pkg holds:
  - localparams SPMV_AXI_ADDR_W=48, SPMV_AXI_DATA_W=256, SPMV_AXI_LEN_W=8.
  - the getvec slice macro's function equivalent.
  - typedef spmv_ar_t struct {addr, len, size, burst}.
- Sub-module spmv_val_id_fifo:
  - sync FIFO, width $clog2(N), depth OUTSTANDING_DEPTH.
  - ports push/pop/din/dout/empty/full/count.
  - show-ahead (head visible while non-empty), sync active-low reset.

Test Plan:
- Single request: kernel 2 issues AR addr 0x1000 len 3 → m_arvalid next cycle with addr 0x1000; 4 R beats reach only kernel 2; outstanding 1→0 after the rlast beat.
- Fairness: all 4 kernels hold arvalid, HBM arready=1 → grant order 0,1,2,3,0,1...; no kernel granted twice before every other requester is granted once.
- Order: kernel 1 then kernel 3 issue len 1 bursts; HBM returns 2+2 beats → first two routed to kernel 1, next two to kernel 3; s_rvalid never high for kernel 0 or 2.
- Backpressure and full: DEPTH=16, HBM never returns data → 16 grants, then all s_arready=0; one rlast beat returns → exactly one more grant, on the cycle after the pop.
- Stalls: kernel 0 rready=0 for 5 cycles mid-burst → m_rready=0 for those 5 cycles, beat held, no data loss; m_arready=0 holds AR fields stable.
- Unexpected R and reset: m_rvalid with empty FIFO → err_unexpected_r=1, m_rready=0; rstn=0 mid-burst → outstanding=0, m_arvalid=0, err cleared next cycle.

Source files
------------

// File: rtl/spmv_pkg.sv
// Shared AXI widths, AR request struct and flattened-vector slicing helper
// for the spmv HBM crossbar blocks.
package spmv_pkg;

    localparam int SPMV_AXI_ADDR_W = 48;
    localparam int SPMV_AXI_DATA_W = 256;
    localparam int SPMV_AXI_LEN_W  = 8;

    typedef struct packed {
        logic [SPMV_AXI_ADDR_W-1:0] addr;
        logic [SPMV_AXI_LEN_W-1:0]  len;
        logic [2:0]                 size;
        logic [1:0]                 burst;
    } spmv_ar_t;

    // Low bit of slice idx in a flattened vector of w-bit per-kernel fields.
    function automatic int getvec_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/spmv_val_id_fifo.sv
// Show-ahead synchronous FIFO holding the kernel index of each granted
// read burst, so R beats can be returned to their owner in grant order.
module spmv_val_id_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which
    // entries are valid, and a reset-free array maps onto plain RAM/registers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/spmv_val_rd_arbiter.sv
// Shares the HBM Val read port among the spmv kernels: round-robin AR
// arbitration, in-order R return via a grant-order FIFO, write side tied off.
module spmv_val_rd_arbiter
    import spmv_pkg::*;
#(
    parameter int CONF_NUM_KERNEL   = 4,
    parameter int OUTSTANDING_DEPTH = 16,
    parameter int ADDR_W            = SPMV_AXI_ADDR_W,
    parameter int DATA_W            = SPMV_AXI_DATA_W
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [CONF_NUM_KERNEL*ADDR_W-1:0] s_axi_Val_araddr,
    input  logic [CONF_NUM_KERNEL*8-1:0]  s_axi_Val_arlen,
    input  logic [CONF_NUM_KERNEL*3-1:0]  s_axi_Val_arsize,
    input  logic [CONF_NUM_KERNEL*2-1:0]  s_axi_Val_arburst,
    input  logic [CONF_NUM_KERNEL-1:0]    s_axi_Val_arvalid,
    output logic [CONF_NUM_KERNEL-1:0]    s_axi_Val_arready,
    output logic [CONF_NUM_KERNEL*DATA_W-1:0] s_axi_Val_rdata,
    output logic [CONF_NUM_KERNEL*2-1:0]  s_axi_Val_rresp,
    output logic [CONF_NUM_KERNEL-1:0]    s_axi_Val_rlast,
    output logic [CONF_NUM_KERNEL-1:0]    s_axi_Val_rvalid,
    input  logic [CONF_NUM_KERNEL-1:0]    s_axi_Val_rready,
    output logic [CONF_NUM_KERNEL-1:0]    s_axi_Val_awready,
    output logic [CONF_NUM_KERNEL-1:0]    s_axi_Val_wready,
    output logic [CONF_NUM_KERNEL-1:0]    s_axi_Val_bvalid,
    output logic [CONF_NUM_KERNEL*2-1:0]  s_axi_Val_bresp,
    output logic [ADDR_W-1:0]             m_axi_hbm_Val_araddr,
    output logic [7:0]                    m_axi_hbm_Val_arlen,
    output logic [2:0]                    m_axi_hbm_Val_arsize,
    output logic [1:0]                    m_axi_hbm_Val_arburst,
    output logic                          m_axi_hbm_Val_arvalid,
    input  logic                          m_axi_hbm_Val_arready,
    input  logic [DATA_W-1:0]             m_axi_hbm_Val_rdata,
    input  logic [1:0]                    m_axi_hbm_Val_rresp,
    input  logic                          m_axi_hbm_Val_rlast,
    input  logic                          m_axi_hbm_Val_rvalid,
    output logic                          m_axi_hbm_Val_rready,
    output logic [ADDR_W-1:0]             m_axi_hbm_Val_awaddr,
    output logic [7:0]                    m_axi_hbm_Val_awlen,
    output logic [2:0]                    m_axi_hbm_Val_awsize,
    output logic [1:0]                    m_axi_hbm_Val_awburst,
    output logic                          m_axi_hbm_Val_awvalid,
    output logic [DATA_W-1:0]             m_axi_hbm_Val_wdata,
    output logic [DATA_W/8-1:0]           m_axi_hbm_Val_wstrb,
    output logic                          m_axi_hbm_Val_wlast,
    output logic                          m_axi_hbm_Val_wvalid,
    output logic                          m_axi_hbm_Val_bready,
    output logic [$clog2(OUTSTANDING_DEPTH):0] outstanding,
    output logic                          err_unexpected_r
);

    localparam int N   = CONF_NUM_KERNEL;
    localparam int IDW = $clog2(N);

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] cand;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] owner;
    logic           any_req;
    logic           grant_en;
    logic           grant;
    logic           pop;
    logic           fifo_empty;
    logic           fifo_full;
    logic           m_arvalid_q;
    spmv_ar_t       ar_q;

    // NOTE: every always_comb output gets a default before the loop, otherwise
    // the paths with no requester would infer latches.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        cand    = '0;
        // Walk downward so the last hit is the closest requester at/after rr_ptr.
        for (int k = N - 1; k >= 0; k--) begin
            cand = IDW'((int'(rr_ptr) + k) % N);
            if (s_axi_Val_arvalid[cand]) begin
                winner  = cand;
                any_req = 1'b1;
            end
        end
    end

    assign grant_en = rstn && (!m_arvalid_q || m_axi_hbm_Val_arready) && !fifo_full;
    assign grant    = grant_en && any_req;
    assign s_axi_Val_arready = grant ? ({{(N-1){1'b0}}, 1'b1} << winner) : '0;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            m_arvalid_q      <= 1'b0;
            ar_q             <= '0;
            rr_ptr           <= '0;
            err_unexpected_r <= 1'b0;
        end else begin
            if (grant) begin
                m_arvalid_q <= 1'b1;
                ar_q.addr   <= s_axi_Val_araddr[getvec_lo(int'(winner), ADDR_W) +: ADDR_W];
                ar_q.len    <= s_axi_Val_arlen[getvec_lo(int'(winner), 8) +: 8];
                ar_q.size   <= s_axi_Val_arsize[getvec_lo(int'(winner), 3) +: 3];
                ar_q.burst  <= s_axi_Val_arburst[getvec_lo(int'(winner), 2) +: 2];
                rr_ptr      <= IDW'((int'(winner) + 1) % N);
            end else if (m_axi_hbm_Val_arready) begin
                m_arvalid_q <= 1'b0;
            end
            if (fifo_empty && m_axi_hbm_Val_rvalid) err_unexpected_r <= 1'b1;
        end
    end

    assign m_axi_hbm_Val_arvalid = m_arvalid_q;
    assign m_axi_hbm_Val_araddr  = ar_q.addr;
    assign m_axi_hbm_Val_arlen   = ar_q.len;
    assign m_axi_hbm_Val_arsize  = ar_q.size;
    assign m_axi_hbm_Val_arburst = ar_q.burst;

    spmv_val_id_fifo #(
        .WIDTH (IDW),
        .DEPTH (OUTSTANDING_DEPTH)
    ) u_id_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (grant),
        .pop   (pop),
        .din   (winner),
        .dout  (owner),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (outstanding)
    );

    // R beats with no recorded owner are refused rather than guessed at.
    always_comb begin
        s_axi_Val_rvalid     = '0;
        m_axi_hbm_Val_rready = 1'b0;
        if (!fifo_empty) begin
            s_axi_Val_rvalid[owner] = m_axi_hbm_Val_rvalid;
            m_axi_hbm_Val_rready    = s_axi_Val_rready[owner];
        end
    end

    assign pop = !fifo_empty && m_axi_hbm_Val_rvalid && m_axi_hbm_Val_rready && m_axi_hbm_Val_rlast;

    assign s_axi_Val_rdata = {N{m_axi_hbm_Val_rdata}};
    assign s_axi_Val_rresp = {N{m_axi_hbm_Val_rresp}};
    assign s_axi_Val_rlast = {N{m_axi_hbm_Val_rlast}};

    assign s_axi_Val_awready     = '0;
    assign s_axi_Val_wready      = '0;
    assign s_axi_Val_bvalid      = '0;
    assign s_axi_Val_bresp       = '0;
    assign m_axi_hbm_Val_awaddr  = '0;
    assign m_axi_hbm_Val_awlen   = '0;
    assign m_axi_hbm_Val_awsize  = '0;
    assign m_axi_hbm_Val_awburst = '0;
    assign m_axi_hbm_Val_awvalid = 1'b0;
    assign m_axi_hbm_Val_wdata   = '0;
    assign m_axi_hbm_Val_wstrb   = '0;
    assign m_axi_hbm_Val_wlast   = 1'b0;
    assign m_axi_hbm_Val_wvalid  = 1'b0;
    assign m_axi_hbm_Val_bready  = 1'b1;

endmodule
